// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory read bus between fetch unit and memory
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Thumb instruction fetch stage with branch redirect and bus timeout
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_start,
  input  logic         branch_en,
  input  logic [31:0]  branch_target,
  fetch_unit_if.master bus,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output logic         is_32bit,
  output logic         instr_valid,
  output logic         fetch_busy,
  output logic         fetch_err,
  output logic [31:0]  pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ1 = 2'd1,
    REQ2 = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT   = {RESET_PC[31:1], 1'b0};
  // Timeout fires on the MAX_WAIT-th unanswered request cycle.
  localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] lo_half;
  logic [31:0] start_pc;

  logic [15:0] half;
  logic        half_is_prefix;
  logic [31:0] branch_pc;
  logic [31:0] next_pc;

  // Pick the halfword addressed by pc[1] and detect a 32-bit Thumb-2 prefix (0b11101/11110/11111).
  always_comb begin
    half           = pc[1] ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
    half_is_prefix = (half[15:13] == 3'b111) && (half[12:11] != 2'b00);
  end

  assign branch_pc     = {branch_target[31:1], 1'b0};
  assign next_pc       = pc + 32'd2;
  assign fetch_busy    = (state != IDLE);
  assign bus.imem_req  = fetch_busy;
  assign bus.imem_addr = fetch_busy ? {pc[31:2], 2'b00} : 32'h0;

  // Fetch FSM: owns the PC, assembles halfwords and raises registered valid/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      wait_cnt    <= 8'd0;
      lo_half     <= 16'h0;
      start_pc    <= PC_INIT;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      is_32bit    <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (branch_en) begin
            pc <= branch_pc;
          end else if (fetch_start) begin
            start_pc <= pc;
            state    <= REQ1;
          end
        end
        REQ1, REQ2: begin
          if (branch_en) begin
            // Redirect wins over any returning data; partial instruction is dropped.
            pc       <= branch_pc;
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end else if (bus.imem_ready) begin
            pc       <= next_pc;
            wait_cnt <= 8'd0;
            if (state == REQ1) begin
              lo_half <= half;
              if (half_is_prefix) begin
                state <= REQ2;
              end else begin
                state       <= IDLE;
                instr_valid <= 1'b1;
                instr_pc    <= start_pc;
                instr       <= {16'h0, half};
                is_32bit    <= 1'b0;
              end
            end else begin
              state       <= IDLE;
              instr_valid <= 1'b1;
              instr_pc    <= start_pc;
              instr       <= {half, lo_half};
              is_32bit    <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory never answered: rewind to the instruction start so it can be retried.
            state     <= IDLE;
            pc        <= start_pc;
            fetch_err <= 1'b1;
            wait_cnt  <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a halfword-level memory model
`timescale 1ns/1ps
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        is32;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        is_32bit;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;
  logic [31:0] pc;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .branch_en(branch_en),
    .branch_target(branch_target), .bus(bus), .instr(instr), .instr_pc(instr_pc),
    .is_32bit(is_32bit), .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err), .pc(pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  exp_t        exp_q [$];
  logic [31:0] model_pc;
  int          tests = 0;
  int          fails = 0;
  int          err_seen = 0;
  bit          auto_mem = 1'b1;
  bit          mem_on = 1'b1;
  int          wait_cfg = 0;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic bit is_long(input logic [15:0] h);
    return (h[15:11] == 5'b11101) || (h[15:11] == 5'b11110) || (h[15:11] == 5'b11111);
  endfunction

  // Memory responder: configurable wait states, or manual control of ready/rdata.
  initial begin
    int wl;
    wl = 0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!auto_mem) begin
        bus.imem_ready = man_ready;
        bus.imem_rdata = man_rdata;
      end else begin
        if (bus.imem_ready || !bus.imem_req) wl = wait_cfg;
        if (bus.imem_req && mem_on && wl == 0) begin
          bus.imem_ready = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr[7:2]];
        end else begin
          bus.imem_ready = 1'b0;
          if (bus.imem_req && mem_on && wl > 0) wl--;
        end
      end
    end
  end

  // Monitor: every delivered instruction is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_err) err_seen++;
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_without_expect", {31'h0, instr_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("instr", instr, e.instr);
          check("instr_pc", instr_pc, e.ipc);
          check("is_32bit", {31'h0, is_32bit}, {31'h0, e.is32});
        end
      end
    end
  end

  task automatic set_pc(input logic [31:0] t);
    branch_en = 1'b1;
    branch_target = t;
    @(negedge clk);
    branch_en = 1'b0;
    model_pc = t & ~32'h1;
    check("pc_branch", pc, model_pc);
  endtask

  task automatic issue_fetch(input bit chk_addr, input logic [31:0] exp_addr0, output int cycles);
    exp_t e;
    logic [15:0] h0;
    int n;
    h0 = half_at(model_pc);
    e.ipc = model_pc;
    if (is_long(h0)) begin
      e.instr = {half_at(model_pc + 32'd2), h0};
      e.is32 = 1'b1;
      model_pc = model_pc + 32'd4;
    end else begin
      e.instr = {16'h0, h0};
      e.is32 = 1'b0;
      model_pc = model_pc + 32'd2;
    end
    exp_q.push_back(e);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    if (chk_addr) check("first_addr", bus.imem_addr, exp_addr0);
    n = 0;
    while (fetch_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("fetch_done_timeout", {31'h0, fetch_busy}, 32'h0);
    check("valid_at_done", {31'h0, instr_valid}, 32'h1);
    check("pc_after", pc, model_pc);
    cycles = n;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    logic [31:0] p;
    logic [15:0] h;
    rst = 1'b1;
    fetch_start = 1'b0;
    branch_en = 1'b0;
    branch_target = 32'h0;
    model_pc = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hBF00_2001;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_busy", {31'h0, fetch_busy}, 32'h0);
    check("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'h0);
    check("rst_instr", instr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue_fetch(1'b1, 32'h0, cyc);
    check("latency_16bit", cyc, 1);
    issue_fetch(1'b1, 32'h0, cyc);

    mem[1] = 32'hF000_0000;
    mem[2] = 32'h0000_F802;
    set_pc(32'h6);
    issue_fetch(1'b1, 32'h4, cyc);
    check("latency_32bit_split", cyc, 2);

    set_pc(32'h0);
    wait_cfg = 3;
    issue_fetch(1'b1, 32'h0, cyc);
    check("latency_3_waits", cyc, 4);
    wait_cfg = 0;

    mem_on = 1'b0;
    p = model_pc;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    n = 0;
    while (bus.imem_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, 15);
    check("timeout_err", {31'h0, fetch_err}, 32'h1);
    check("timeout_no_valid", {31'h0, instr_valid}, 32'h0);
    check("timeout_pc", pc, p);
    mem_on = 1'b1;

    set_pc(32'h6);
    auto_mem = 1'b0;
    man_ready = 1'b0;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    man_ready = 1'b1;
    man_rdata = mem[1];
    @(negedge clk);
    check("req2_addr", bus.imem_addr, 32'h8);
    man_rdata = mem[2];
    branch_en = 1'b1;
    branch_target = 32'h0000_0101;
    @(negedge clk);
    branch_en = 1'b0;
    man_ready = 1'b0;
    auto_mem = 1'b1;
    check("abort_req", {31'h0, bus.imem_req}, 32'h0);
    check("abort_pc", pc, 32'h100);
    check("abort_no_valid", {31'h0, instr_valid}, 32'h0);
    model_pc = 32'h100;
    issue_fetch(1'b1, 32'h100, cyc);

    mem[63] = 32'h2001_4444;
    set_pc(32'hFFFF_FFFE);
    issue_fetch(1'b1, 32'hFFFF_FFFC, cyc);
    check("wrap_pc", pc, 32'h0);

    mem_on = 1'b0;
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_on = 1'b1;
    model_pc = 32'h0;
    check("midrst_pc", pc, 32'h0);
    check("midrst_req", {31'h0, bus.imem_req}, 32'h0);
    check("midrst_busy", {31'h0, fetch_busy}, 32'h0);
    check("midrst_valid", {31'h0, instr_valid}, 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_instr_pc", instr_pc, 32'h0);
    check("midrst_is32", {31'h0, is_32bit}, 32'h0);

    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 2; k++) begin
        h = 16'($urandom);
        if ($urandom % 3 == 0) h[15:11] = 5'b11101 + 5'($urandom % 3);
        if (k == 0) mem[i][15:0] = h;
        else mem[i][31:16] = h;
      end
    end
    for (int it = 0; it < 60; it++) begin
      if ($urandom % 4 == 0) set_pc($urandom & 32'h0000_00FF);
      wait_cfg = int'($urandom % 4);
      issue_fetch(1'b0, 32'h0, cyc);
    end
    wait_cfg = 0;

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("err_pulses", err_seen, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
